// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
package shared_reg_arbiter_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {IDLE, GRANTED} state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic int unsigned owner_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of vec[num-1:0], scanning upward from ptr with wrap-around.
  function automatic rr_pick_t rr_first(input logic [MAX_REQ-1:0] vec,
                                        input int unsigned num,
                                        input int unsigned ptr);
    rr_pick_t    pick;
    int unsigned cand;
    pick = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      cand = (ptr + i) % num;
      if (i < num && !pick.found && vec[cand[IDX_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = cand[IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/shared_reg_store.sv
// Enable-gated D register with synchronous clear; clear wins over enable.
module shared_reg_store #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  always_ff @(posedge clk) begin
    if (clear)   q <= '0;
    else if (en) q <= d;
  end

  assign q_bar = ~q;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter with optional bounded lock, sequencing writes of the
// granted requester's data into one shared register.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         lock,
  input  logic [NUM_REQ*WIDTH-1:0]   data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         ack,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           q_bar
);

  localparam int unsigned        OWNER_W   = owner_width(NUM_REQ);
  localparam int unsigned        HOLD_W    = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [OWNER_W-1:0] LAST_REQ  = OWNER_W'(NUM_REQ - 1);

  state_t             state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [OWNER_W-1:0] next_ptr;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [NUM_REQ-1:0] owner_hot;
  logic [MAX_REQ-1:0] scan_vec;
  logic               wr_en;
  logic               keep;
  logic [WIDTH-1:0]   wr_data;
  rr_pick_t           pick;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
    end
  end

  // In GRANTED the scan already starts from the post-release pointer and
  // skips the owner, so a handover needs no idle bubble.
  always_comb begin
    wr_en    = (state_q == GRANTED) && req[owner_q];
    keep     = wr_en && lock[owner_q] && (hold_q < HOLD_LAST);
    next_ptr = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;
    scan_vec = '0;
    scan_vec[NUM_REQ-1:0] = (state_q == GRANTED) ? (req & ~owner_hot) : req;
    pick     = rr_first(scan_vec, NUM_REQ,
                        (state_q == GRANTED) ? int'(next_ptr) : int'(rr_ptr_q));
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    case (state_q)
      IDLE: begin
        if (pick.found) begin
          state_d = GRANTED;
          owner_d = OWNER_W'(pick.idx);
          hold_d  = '0;
        end
      end
      GRANTED: begin
        if (keep) begin
          hold_d = hold_q + 1'b1;
        end else begin
          rr_ptr_d = next_ptr;
          hold_d   = '0;
          if (pick.found) owner_d = OWNER_W'(pick.idx);
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_hot = NUM_REQ'(1) << owner_q;
    busy      = (state_q == GRANTED);
    gnt       = busy  ? owner_hot : '0;
    ack       = wr_en ? owner_hot : '0;
    wr_data   = data[owner_q*WIDTH +: WIDTH];
  end

  assign owner = owner_q;

  shared_reg_store #(.WIDTH(WIDTH)) u_store (
    .clk   (clk),
    .clear (reset),
    .en    (wr_en),
    .d     (wr_data),
    .q     (q),
    .q_bar (q_bar)
  );

endmodule
